fpu_issue_arbiter: RTL

- Shares the single combinational FPU (add/mul, FPUcontrol 1=add, 0=mul) between two requesters, e.g. the core's execute stage and a vector/DMA helper.
- Each requester uses a valid/ready request channel. The block arbitrates round-robin and registers the operands that drive the FPU inputs.
- It holds the operands stable for a programmable number of cycles (multicycle path through the FPU), captures the result, and returns it on a single tagged response channel with valid/ready.

---
 rtl/fpu_issue_arbiter_if.sv | 56 +++++
 rtl/fpu_issue_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arbiter_if.sv
// Bundle of the two request channels, the FPU operand/result wires and the tagged response
// channel. The master modport is the arbiter's view; the slave modport is the surroundings.
interface fpu_issue_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_op;
  logic [31:0]       req0_a;
  logic [31:0]       req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_op;
  logic [31:0]       req1_a;
  logic [31:0]       req1_b;

  logic              fpu_ctrl;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic [31:0]       fpu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_nan;

  logic              busy;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport master (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output fpu_ctrl, fpu_a, fpu_b,
    input  fpu_result,
    output rsp_valid, rsp_id, rsp_result, rsp_nan,
    input  rsp_ready,
    output busy, cnt0, cnt1
  );

  modport slave (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  fpu_ctrl, fpu_a, fpu_b,
    output fpu_result,
    input  rsp_valid, rsp_id, rsp_result, rsp_nan,
    output rsp_ready,
    input  busy, cnt0, cnt1
  );
endinterface

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one combinational FPU between two requesters.
// Define FPU_ARB_OPCNT_EN to enable the saturating per-requester completed-op counters.
module fpu_issue_arbiter #(
  parameter int unsigned FPU_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fpu_issue_arbiter_if.master  bus
);

  localparam int unsigned      LAT_W    = 4;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FPU_LAT - 1);
  localparam logic [31:0]      NAN_ENC  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic              prio_q,       prio_d;
  logic [LAT_W-1:0]  lat_q,        lat_d;
  logic              id_q,         id_d;
  logic              fpu_ctrl_q,   fpu_ctrl_d;
  logic [31:0]       fpu_a_q,      fpu_a_d;
  logic [31:0]       fpu_b_q,      fpu_b_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic              rsp_id_q,     rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_nan_q,    rsp_nan_d;
  logic              busy_q,       busy_d;

  logic [1:0]        req_valid_c;
  logic [1:0]        req_ready_c;
  logic              grant_vld_c;
  logic              grant_id_c;

  // Arbitration, operand capture, FPU hold countdown and response hand-off.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    lat_d        = lat_q;
    id_d         = id_q;
    fpu_ctrl_d   = fpu_ctrl_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_nan_d    = rsp_nan_q;
    req_ready_c  = 2'b00;
    req_valid_c  = {bus.req1_valid, bus.req0_valid};
    grant_vld_c  = 1'b0;
    grant_id_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Priority holder first, otherwise whichever other requester is valid.
        grant_vld_c = |req_valid_c;
        grant_id_c  = req_valid_c[prio_q] ? prio_q : ~prio_q;
        if (grant_vld_c) begin
          req_ready_c[grant_id_c] = 1'b1;
          id_d    = grant_id_c;
          lat_d   = LAT_LOAD;
          state_d = ST_EXEC;
          if (grant_id_c) begin
            fpu_ctrl_d = bus.req1_op;
            fpu_a_d    = bus.req1_a;
            fpu_b_d    = bus.req1_b;
          end else begin
            fpu_ctrl_d = bus.req0_op;
            fpu_a_d    = bus.req0_a;
            fpu_b_d    = bus.req0_b;
          end
        end
      end
      ST_EXEC: begin
        if (lat_q == LAT_W'(0)) begin
          rsp_result_d = bus.fpu_result;
          rsp_nan_d    = (bus.fpu_result == NAN_ENC);
          rsp_id_d     = id_q;
          state_d      = ST_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          prio_d  = ~id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      lat_q        <= '0;
      id_q         <= 1'b0;
      fpu_ctrl_q   <= 1'b0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_nan_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      lat_q        <= lat_d;
      id_q         <= id_d;
      fpu_ctrl_q   <= fpu_ctrl_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_nan_q    <= rsp_nan_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = req_ready_c[0];
  assign bus.req1_ready = req_ready_c[1];
  assign bus.fpu_ctrl   = fpu_ctrl_q;
  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_nan    = rsp_nan_q;
  assign bus.busy       = busy_q;

`ifdef FPU_ARB_OPCNT_EN
  logic              rsp_fire_c;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  // Saturating count of accepted responses per owner.
  always_comb begin
    rsp_fire_c = (state_q == ST_RESP) && bus.rsp_ready;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (rsp_fire_c && !rsp_id_q && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
    if (rsp_fire_c &&  rsp_id_q && !(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
  assign bus.cnt0 = CNT_W'(0);
  assign bus.cnt1 = CNT_W'(0);
`endif

endmodule
